vertex_mem_responder: RTL and testbench



---
 rtl/vertex_mem_responder.sv | 206 ++++++++++++++++++++
 tb/tb_vertex_mem_responder.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/vertex_mem_responder.sv
// Responder for the vertex-engine read/write burst interface, backed by an on-chip line store.
// Optional VMEM_READ_REG_EN adds an output register on ReadData/ReadReady (read latency +1).
module vertex_mem_responder #(
    parameter int unsigned DATAWIDTH = 256,
    parameter int unsigned MEM_DEPTH = 1024,
    parameter int unsigned ADDR_W    = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 StartRead,
    input  logic [7:0]           ReadBurst,
    input  logic [32:0]          ReadAddress,
    output logic [DATAWIDTH-1:0] ReadData,
    output logic                 ReadReady,
    output logic                 EndRead,
    input  logic                 StartWrite,
    input  logic [7:0]           WriteBurst,
    input  logic [32:0]          WriteAddress,
    input  logic [DATAWIDTH-1:0] WriteData,
    input  logic                 WriteReady,
    output logic                 WriteLast,
    output logic                 WriteResp,
    output logic                 EndWrite,
    input  logic                 host_we,
    input  logic [ADDR_W-1:0]    host_addr,
    input  logic [DATAWIDTH-1:0] host_wdata,
    output logic                 busy,
    output logic                 cmd_overflow
);

    localparam int unsigned BURST_W  = 8;
    localparam int unsigned CNT_W    = 9;
    localparam int unsigned BADDR_W  = 33;
    localparam int unsigned LINE_LSB = 5;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD      = 3'd1,
        RD_END  = 3'd2,
        WR      = 3'd3,
        WR_RESP = 3'd4,
        WR_END  = 3'd5
    } vmState_t;

    vmState_t state;
    vmState_t nextState;

    logic [DATAWIDTH-1:0] mem [MEM_DEPTH];
    logic [DATAWIDTH-1:0] memQ;
    logic                 rdValid;
    logic                 inFlight;

    logic [ADDR_W-1:0]  curIdx;
    logic [BURST_W-1:0] curBurst;
    logic [CNT_W-1:0]   beatCnt;

    logic               pendWrValid, pendRdValid;
    logic [ADDR_W-1:0]  pendWrIdx, pendRdIdx;
    logic [BURST_W-1:0] pendWrBurst, pendRdBurst;
    logic               overflowQ;
    logic               writeRespQ, endWriteQ, endReadQ;

    logic [ADDR_W-1:0]  startRdIdx, startWrIdx;
    logic               decide, takeWr, takeRd;
    logic [ADDR_W-1:0]  newIdx;
    logic [BURST_W-1:0] newBurst;
    logic               latchWr, dropWr, latchRd, dropRd;
    logic               issueRd, acceptWr, lastBeat, wrLast, hostWrEn;
    logic               unusedBits;

    assign startRdIdx = ReadAddress[LINE_LSB +: ADDR_W];
    assign startWrIdx = WriteAddress[LINE_LSB +: ADDR_W];
    assign unusedBits = ^{ReadAddress[LINE_LSB-1:0], ReadAddress[BADDR_W-1:LINE_LSB+ADDR_W],
                          WriteAddress[LINE_LSB-1:0], WriteAddress[BADDR_W-1:LINE_LSB+ADDR_W]};

    // Command arbitration: writes before reads, pending slot before a fresh strobe of the same type.
    always_comb begin
        decide   = (state == IDLE) || (state == WR_END);
        takeWr   = decide && (pendWrValid || StartWrite);
        takeRd   = decide && !takeWr && (pendRdValid || StartRead);
        newIdx   = startRdIdx;
        newBurst = ReadBurst;
        if (takeWr) begin
            newIdx   = pendWrValid ? pendWrIdx   : startWrIdx;
            newBurst = pendWrValid ? pendWrBurst : WriteBurst;
        end else if (pendRdValid) begin
            newIdx   = pendRdIdx;
            newBurst = pendRdBurst;
        end
        latchWr = StartWrite && (pendWrValid ? takeWr : !takeWr);
        dropWr  = StartWrite && pendWrValid && !takeWr;
        latchRd = StartRead && (pendRdValid ? takeRd : !takeRd);
        dropRd  = StartRead && pendRdValid && !takeRd;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE, WR_END: begin
                if (takeWr)      nextState = WR;
                else if (takeRd) nextState = RD;
                else             nextState = IDLE;
            end
            RD:      if (lastBeat)  nextState = RD_END;
            RD_END:  if (!inFlight) nextState = IDLE;
            WR:      if (wrLast)    nextState = WR_RESP;
            WR_RESP: nextState = WR_END;
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        issueRd  = (state == RD);
        acceptWr = (state == WR) && WriteReady;
        lastBeat = (beatCnt == CNT_W'(curBurst));
        wrLast   = acceptWr && lastBeat;
        hostWrEn = host_we && !busy && !StartRead && !StartWrite;
    end

    assign WriteLast    = wrLast;
    assign busy         = (state != IDLE) || pendWrValid || pendRdValid;
    assign cmd_overflow = overflowQ;
    assign WriteResp    = writeRespQ;
    assign EndWrite     = endWriteQ;
    assign EndRead      = endReadQ;

    // Line store write port; host patches only land while the block is quiet.
    always_ff @(posedge clk) begin
        if (acceptWr)      mem[curIdx]    <= WriteData;
        else if (hostWrEn) mem[host_addr] <= host_wdata;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pendWrValid <= 1'b0;
            pendRdValid <= 1'b0;
            pendWrIdx   <= '0;
            pendRdIdx   <= '0;
            pendWrBurst <= '0;
            pendRdBurst <= '0;
            overflowQ   <= 1'b0;
            curIdx      <= '0;
            curBurst    <= '0;
            beatCnt     <= '0;
            rdValid     <= 1'b0;
            memQ        <= '0;
            writeRespQ  <= 1'b0;
            endWriteQ   <= 1'b0;
            endReadQ    <= 1'b0;
        end else begin
            pendWrValid <= (pendWrValid && !takeWr) || latchWr;
            pendRdValid <= (pendRdValid && !takeRd) || latchRd;
            if (latchWr) begin
                pendWrIdx   <= startWrIdx;
                pendWrBurst <= WriteBurst;
            end
            if (latchRd) begin
                pendRdIdx   <= startRdIdx;
                pendRdBurst <= ReadBurst;
            end
            overflowQ <= overflowQ || dropWr || dropRd;
            if (takeWr || takeRd) begin
                curIdx   <= newIdx;
                curBurst <= newBurst;
                beatCnt  <= '0;
            end else if (issueRd || acceptWr) begin
                curIdx  <= curIdx + ADDR_W'(1);
                beatCnt <= beatCnt + CNT_W'(1);
            end
            rdValid <= issueRd;
            if (issueRd) memQ <= mem[curIdx];
            writeRespQ <= wrLast;
            endWriteQ  <= (state == WR_RESP);
            endReadQ   <= (state == RD_END) && !inFlight;
        end
    end

`ifdef VMEM_READ_REG_EN
    logic [DATAWIDTH-1:0] readDataQ;
    logic                 readReadyQ;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            readDataQ  <= '0;
            readReadyQ <= 1'b0;
        end else begin
            readDataQ  <= memQ;
            readReadyQ <= rdValid;
        end
    end

    assign ReadData  = readDataQ;
    assign ReadReady = readReadyQ;
    assign inFlight  = rdValid;
`else
    assign ReadData  = memQ;
    assign ReadReady = rdValid;
    assign inFlight  = 1'b0;
`endif

endmodule

// File: tb/tb_vertex_mem_responder.sv
// Directed bench for vertex_mem_responder: host preload, bursts, wrap, arbitration, overflow, reset.
module tb_vertex_mem_responder;

    localparam int DW = 256;
`ifdef VMEM_READ_REG_EN
    localparam int RL = 3;
`else
    localparam int RL = 2;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          StartRead = 1'b0;
    logic [7:0]    ReadBurst = '0;
    logic [32:0]   ReadAddress = '0;
    logic [DW-1:0] ReadData;
    logic          ReadReady;
    logic          EndRead;
    logic          StartWrite = 1'b0;
    logic [7:0]    WriteBurst = '0;
    logic [32:0]   WriteAddress = '0;
    logic [DW-1:0] WriteData = '0;
    logic          WriteReady = 1'b0;
    logic          WriteLast;
    logic          WriteResp;
    logic          EndWrite;
    logic          host_we = 1'b0;
    logic [9:0]    host_addr = '0;
    logic [DW-1:0] host_wdata = '0;
    logic          busy;
    logic          cmd_overflow;

    always #5 clk = ~clk;

    vertex_mem_responder dut (
        .clk(clk), .reset(reset),
        .StartRead(StartRead), .ReadBurst(ReadBurst), .ReadAddress(ReadAddress),
        .ReadData(ReadData), .ReadReady(ReadReady), .EndRead(EndRead),
        .StartWrite(StartWrite), .WriteBurst(WriteBurst), .WriteAddress(WriteAddress),
        .WriteData(WriteData), .WriteReady(WriteReady), .WriteLast(WriteLast),
        .WriteResp(WriteResp), .EndWrite(EndWrite),
        .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .busy(busy), .cmd_overflow(cmd_overflow)
    );

    logic [DW-1:0] model [1024];
    int vecCnt = 0;
    int errCnt = 0;

    task automatic checkVal(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        vecCnt++;
        if (got !== exp) begin
            errCnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic checkQuiet(input string tag);
        checkVal({tag, "_rdy"},  DW'(ReadReady),    '0);
        checkVal({tag, "_data"}, ReadData,          '0);
        checkVal({tag, "_endr"}, DW'(EndRead),      '0);
        checkVal({tag, "_wlst"}, DW'(WriteLast),    '0);
        checkVal({tag, "_wrsp"}, DW'(WriteResp),    '0);
        checkVal({tag, "_endw"}, DW'(EndWrite),     '0);
        checkVal({tag, "_busy"}, DW'(busy),         '0);
        checkVal({tag, "_ovf"},  DW'(cmd_overflow), '0);
    endtask

    task automatic hostWrite(input int idx, input logic [DW-1:0] d);
        @(negedge clk);
        host_we = 1'b1; host_addr = 10'(idx); host_wdata = d;
        model[idx] = d;
        @(negedge clk);
        host_we = 1'b0;
    endtask

    function automatic logic [32:0] lineAddr(input int idx);
        // junk in the byte offset and above the index must be ignored
        return (33'(idx) << 5) | 33'h1f | (33'h1 << 32);
    endfunction

    task automatic runRead(input int idx, input int burst);
        logic expRdy;
        @(negedge clk);
        StartRead = 1'b1; ReadBurst = 8'(burst); ReadAddress = lineAddr(idx);
        for (int c = 1; c <= burst + RL + 1; c++) begin
            @(negedge clk);
            StartRead = 1'b0;
            expRdy = (c >= RL) && (c <= RL + burst);
            checkVal("rd_ready", DW'(ReadReady), DW'(expRdy));
            if (expRdy) checkVal("rd_data", ReadData, model[(idx + c - RL) % 1024]);
            checkVal("rd_end", DW'(EndRead), DW'(c == RL + burst + 1));
        end
    endtask

    initial begin
        logic [DW-1:0] datA, datB, datC, junk;
        logic expRdy;
        datA = {32{8'hA5}};
        datB = {32{8'h5B}};
        datC = {32{8'h5C}};
        junk = {64{4'hF}};

        // reset state
        repeat (2) @(negedge clk);
        checkQuiet("reset");
        reset = 1'b1;

        hostWrite(0, {32{8'h11}});
        hostWrite(1, {32{8'h22}});
        hostWrite(2, {32{8'h33}});
        hostWrite(3, {32{8'h44}});
        hostWrite(10, {32{8'hAA}});
        @(negedge clk);
        checkVal("idle_busy", DW'(busy), '0);

        runRead(0, 3);

        // write across the wrap point with an idle beat in between
        @(negedge clk);
        StartWrite = 1'b1; WriteBurst = 8'd1; WriteAddress = 33'h7FE0;
        WriteReady = 1'b1; WriteData = junk;
        @(negedge clk);
        StartWrite = 1'b0; WriteData = datA;
        #1 checkVal("wlast_a", DW'(WriteLast), '0);
        @(negedge clk);
        WriteReady = 1'b0; WriteData = junk;
        #1 checkVal("wlast_gap", DW'(WriteLast), '0);
        @(negedge clk);
        WriteReady = 1'b1; WriteData = datB;
        #1 checkVal("wlast_b", DW'(WriteLast), 1);
        @(negedge clk);
        WriteReady = 1'b0;
        checkVal("wresp", DW'(WriteResp), 1);
        checkVal("wresp_endw", DW'(EndWrite), '0);
        @(negedge clk);
        checkVal("endw_resp", DW'(WriteResp), '0);
        checkVal("endw", DW'(EndWrite), 1);
        @(negedge clk);
        checkVal("wdone_endw", DW'(EndWrite), '0);
        checkVal("wdone_busy", DW'(busy), '0);
        model[1023] = datA;
        model[0]    = datB;
        runRead(1023, 1);

        // simultaneous strobes: write first, read starts in the EndWrite cycle
        @(negedge clk);
        StartRead = 1'b1; ReadBurst = 8'd0; ReadAddress = lineAddr(2);
        StartWrite = 1'b1; WriteBurst = 8'd0; WriteAddress = lineAddr(5);
        WriteReady = 1'b1; WriteData = junk;
        @(negedge clk);
        StartRead = 1'b0; StartWrite = 1'b0; WriteData = datC;
        #1 checkVal("both_wlast", DW'(WriteLast), 1);
        checkVal("both_busy1", DW'(busy), 1);
        @(negedge clk);
        WriteReady = 1'b0;
        checkVal("both_wresp", DW'(WriteResp), 1);
        checkVal("both_busy2", DW'(busy), 1);
        for (int c = 3; c <= RL + 4; c++) begin
            @(negedge clk);
            checkVal("both_endw", DW'(EndWrite), DW'(c == 3));
            checkVal("both_rdy", DW'(ReadReady), DW'(c == RL + 3));
            if (c == RL + 3) checkVal("both_data", ReadData, {32{8'h33}});
            checkVal("both_endr", DW'(EndRead), DW'(c == RL + 4));
            checkVal("both_busy", DW'(busy), DW'(c <= RL + 3));
        end
        model[5] = datC;
        runRead(5, 0);

        // two extra reads mid-burst: one pends, one drops; host write while busy ignored
        @(negedge clk);
        StartRead = 1'b1; ReadBurst = 8'd3; ReadAddress = lineAddr(0);
        for (int c = 1; c <= 2 * RL + 7; c++) begin
            @(negedge clk);
            StartRead = (c == 1) || (c == 2);
            ReadBurst = 8'd0;
            ReadAddress = lineAddr(c == 1 ? 1 : 3);
            host_we = (c == 3); host_addr = 10'd10; host_wdata = junk;
            expRdy = ((c >= RL) && (c <= RL + 3)) || (c == 2 * RL + 4);
            checkVal("ovf_rdy", DW'(ReadReady), DW'(expRdy));
            if (expRdy) checkVal("ovf_data", ReadData, model[c == 2 * RL + 4 ? 1 : c - RL]);
            checkVal("ovf_endr", DW'(EndRead), DW'((c == RL + 4) || (c == 2 * RL + 5)));
        end
        host_we = 1'b0;
        checkVal("ovf_sticky", DW'(cmd_overflow), 1);
        checkVal("ovf_busy", DW'(busy), '0);
        runRead(10, 0);

        // reset in the middle of a read burst
        @(negedge clk);
        StartRead = 1'b1; ReadBurst = 8'd3; ReadAddress = lineAddr(0);
        for (int c = 1; c <= RL + 2; c++) begin
            @(negedge clk);
            StartRead = 1'b0;
        end
        checkVal("mid_rdy", DW'(ReadReady), 1);
        checkVal("mid_data", ReadData, model[2]);
        reset = 1'b0;
        #1 checkQuiet("mid_reset");
        repeat (3) begin
            @(negedge clk);
            checkVal("rst_endr", DW'(EndRead), '0);
        end
        reset = 1'b1;
        @(negedge clk);
        checkQuiet("post_reset");
        runRead(1, 2);

        // shortest burst
        runRead(3, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCnt, errCnt);
        $finish;
    end

endmodule
